// File: rtl/mat_alu_pkg.sv
// Shared definitions for the 4x4 matrix ALU and the execution engine that drives it.
// Holds element/matrix widths, op-code constants, the ALU state encoding and the
// row-major element offset helper.
package mat_alu_pkg;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned DIM    = 4;
  localparam int unsigned N_ELEM = DIM * DIM;
  localparam int unsigned MAT_W  = ELEM_W * N_ELEM;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned SCAL_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 8'b0000_0001;
  localparam logic [OP_W-1:0] OP_SUB   = 8'b0000_0010;
  localparam logic [OP_W-1:0] OP_SCALE = 8'b0000_0011;
  localparam logic [OP_W-1:0] OP_TRANS = 8'b0000_0100;
  localparam logic [OP_W-1:0] OP_MULTI = 8'b0000_0101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_B  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bit offset of element (r,c) in a row-major packed matrix.
  function automatic logic [7:0] elem_off(input logic [1:0] r, input logic [1:0] c);
    return 8'(ELEM_W * ((32'(r) << 2) + 32'(c)));
  endfunction

  // Ops that need a second operand before computing.
  function automatic logic needs_b(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MULTI);
  endfunction

endpackage

// File: rtl/mat_dot4.sv
// 4-element dot product of a row of A and a column of B.
// Ports: a_row[4], b_col[4] elements in; dot = sum of products truncated to ELEM_W.
module mat_dot4
  import mat_alu_pkg::*;
(
  input  logic [ELEM_W-1:0] a_row [DIM],
  input  logic [ELEM_W-1:0] b_col [DIM],
  output logic [ELEM_W-1:0] dot
);

  localparam int unsigned PROD_W = 2 * ELEM_W;
  localparam int unsigned ACC_W  = PROD_W + 2;

  logic [ACC_W-1:0] acc;

  // Products and their sum kept at full width; truncation happens only at the output.
  always_comb begin
    acc = '0;
    for (int k = 0; k < int'(DIM); k++) begin
      acc = acc + ACC_W'(PROD_W'(a_row[2'(k)]) * PROD_W'(b_col[2'(k)]));
    end
    dot = ELEM_W'(acc);
  end

endmodule

// File: rtl/matrix_alu_seq.sv
// Sequential 4x4 matrix ALU: captures operands on load strobes, computes
// ADD/SUB/SCALE/TRANS one row per cycle and MULTI one element per cycle.
// Ports: clk, reset (async, active-high); Load_Matrix1 captures A/Op_Code/SOURCE2;
// Load_Matrix2 captures B; MemMatIn operand; MemMatOut registered result;
// FinishFlag result-valid level, cleared by the next Load_Matrix1.
module matrix_alu_seq
  import mat_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              Load_Matrix1,
  input  logic              Load_Matrix2,
  input  logic [MAT_W-1:0]  MemMatIn,
  input  logic [OP_W-1:0]   Op_Code,
  input  logic [SCAL_W-1:0] SOURCE2,
  output logic [MAT_W-1:0]  MemMatOut,
  output logic              FinishFlag
);

  state_t              state_q;
  logic [MAT_W-1:0]    a_q;
  logic [MAT_W-1:0]    b_q;
  logic [MAT_W-1:0]    r_q;
  logic [OP_W-1:0]     op_q;
  logic [SCAL_W-1:0]   scalar_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [1:0]          row_c;
  logic [1:0]          col_c;
  logic [ELEM_W-1:0]   a_row_c [DIM];
  logic [ELEM_W-1:0]   b_col_c [DIM];
  logic [ELEM_W-1:0]   dot_c;
  logic [MAT_W-1:0]    r_next_c;
  logic                last_c;
  logic [ELEM_W-1:0]   ea_c;
  logic [ELEM_W-1:0]   eb_c;
  logic [ELEM_W-1:0]   et_c;
  logic [ELEM_W-1:0]   res_c;

  // Counter is a row index for row ops and a row-major element index for MULTI.
  always_comb begin
    row_c = (op_q == OP_MULTI) ? cnt_q[3:2] : cnt_q[1:0];
    col_c = cnt_q[1:0];
    for (int k = 0; k < int'(DIM); k++) begin
      a_row_c[2'(k)] = a_q[elem_off(row_c, 2'(k)) +: ELEM_W];
      b_col_c[2'(k)] = b_q[elem_off(2'(k), col_c) +: ELEM_W];
    end
  end

  mat_dot4 u_dot4 (
    .a_row (a_row_c),
    .b_col (b_col_c),
    .dot   (dot_c)
  );

  // Next partial result: row datapath for element-wise ops, dot product for MULTI.
  always_comb begin
    r_next_c = r_q;
    last_c   = 1'b0;
    ea_c     = '0;
    eb_c     = '0;
    et_c     = '0;
    res_c    = '0;
    case (op_q)
      OP_ADD, OP_SUB, OP_SCALE, OP_TRANS: begin
        last_c = (cnt_q == CNT_W'(DIM - 1));
        for (int c = 0; c < int'(DIM); c++) begin
          ea_c = a_q[elem_off(row_c, 2'(c)) +: ELEM_W];
          eb_c = b_q[elem_off(row_c, 2'(c)) +: ELEM_W];
          et_c = a_q[elem_off(2'(c), row_c) +: ELEM_W];
          case (op_q)
            OP_ADD:   res_c = ea_c + eb_c;
            OP_SUB:   res_c = ea_c - eb_c;
            OP_SCALE: res_c = ea_c * ELEM_W'(scalar_q);
            default:  res_c = et_c;
          endcase
          r_next_c[elem_off(row_c, 2'(c)) +: ELEM_W] = res_c;
        end
      end
      OP_MULTI: begin
        last_c = (cnt_q == CNT_W'(N_ELEM - 1));
        r_next_c[elem_off(row_c, col_c) +: ELEM_W] = dot_c;
      end
      default: begin
        // Unknown op completes immediately with a zero result.
        last_c   = 1'b1;
        r_next_c = '0;
      end
    endcase
  end

  // Control FSM, operand capture and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      op_q       <= '0;
      scalar_q   <= '0;
      cnt_q      <= '0;
      MemMatOut  <= '0;
      FinishFlag <= 1'b0;
    end else begin
      if (Load_Matrix2) begin
        b_q <= MemMatIn;
      end
      if (Load_Matrix1) begin
        // A new A-load restarts from scratch, abandoning any computation in flight.
        a_q        <= MemMatIn;
        op_q       <= Op_Code;
        scalar_q   <= SOURCE2;
        FinishFlag <= 1'b0;
        cnt_q      <= '0;
        r_q        <= '0;
        state_q    <= (needs_b(Op_Code) && !Load_Matrix2) ? WAIT_B : COMPUTE;
      end else begin
        case (state_q)
          WAIT_B: begin
            if (Load_Matrix2) begin
              cnt_q   <= '0;
              state_q <= COMPUTE;
            end
          end
          COMPUTE: begin
            r_q   <= r_next_c;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_c) begin
              MemMatOut  <= r_next_c;
              FinishFlag <= 1'b1;
              state_q    <= DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Testbench for matrix_alu_seq: directed operand loads, a cycle-level reference
// model compared on every falling edge, and literal expectations for each op.
module tb_matrix_alu_seq;

  localparam logic [7:0] ADD   = 8'h01;
  localparam logic [7:0] SUB   = 8'h02;
  localparam logic [7:0] SCALE = 8'h03;
  localparam logic [7:0] TRANS = 8'h04;
  localparam logic [7:0] MULTI = 8'h05;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Load_Matrix1 = 1'b0;
  logic         Load_Matrix2 = 1'b0;
  logic [255:0] MemMatIn = '0;
  logic [7:0]   Op_Code = '0;
  logic [7:0]   SOURCE2 = '0;
  logic [255:0] MemMatOut;
  logic         FinishFlag;

  int checks = 0;
  int errors = 0;

  matrix_alu_seq dut (
    .clk          (clk),
    .reset        (reset),
    .Load_Matrix1 (Load_Matrix1),
    .Load_Matrix2 (Load_Matrix2),
    .MemMatIn     (MemMatIn),
    .Op_Code      (Op_Code),
    .SOURCE2      (SOURCE2),
    .MemMatOut    (MemMatOut),
    .FinishFlag   (FinishFlag)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] el(input logic [255:0] m, input int r, input int c);
    return m[8'((4 * r + c) * 16) +: 16];
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] m;
    for (int i = 0; i < 16; i++) m[8'(i * 16) +: 16] = v;
    return m;
  endfunction

  // Whole-matrix result straight from the arithmetic definitions.
  function automatic logic [255:0] model_result(input logic [7:0] op, input logic [255:0] a,
                                                input logic [255:0] b, input logic [7:0] s);
    logic [255:0]    m;
    longint unsigned x;
    m = '0;
    for (int ri = 0; ri < 4; ri++) begin
      for (int ci = 0; ci < 4; ci++) begin
        case (op)
          ADD:   x = 64'(el(a, ri, ci)) + 64'(el(b, ri, ci));
          SUB:   x = 64'(el(a, ri, ci)) - 64'(el(b, ri, ci));
          SCALE: x = 64'(el(a, ri, ci)) * 64'(s);
          TRANS: x = 64'(el(a, ci, ri));
          MULTI: begin
            x = 0;
            for (int k = 0; k < 4; k++) x = x + 64'(el(a, ri, k)) * 64'(el(b, k, ci));
          end
          default: x = 0;
        endcase
        m[8'((4 * ri + ci) * 16) +: 16] = 16'(x);
      end
    end
    return m;
  endfunction

  function automatic int latency(input logic [7:0] op);
    case (op)
      ADD, SUB, SCALE, TRANS: return 4;
      MULTI:                  return 16;
      default:                return 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model state: expected outputs plus a countdown to completion.
  logic [255:0] m_a = '0, m_b = '0, m_res = '0, exp_out = '0;
  logic [7:0]   m_op = '0, m_s = '0;
  logic         exp_fin = 1'b0, m_wait = 1'b0;
  int           m_cnt = 0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_a = '0; m_b = '0; m_res = '0; exp_out = '0;
      m_op = '0; m_s = '0; exp_fin = 1'b0; m_wait = 1'b0; m_cnt = 0;
    end else begin
      if (Load_Matrix2) m_b = MemMatIn;
      if (Load_Matrix1) begin
        m_a = MemMatIn; m_op = Op_Code; m_s = SOURCE2;
        exp_fin = 1'b0; m_cnt = 0;
        m_wait = ((Op_Code == ADD) || (Op_Code == SUB) || (Op_Code == MULTI)) && !Load_Matrix2;
        if (!m_wait) begin
          m_res = model_result(m_op, m_a, m_b, m_s);
          m_cnt = latency(m_op);
        end
      end else if (m_wait && Load_Matrix2) begin
        m_wait = 1'b0;
        m_res  = model_result(m_op, m_a, m_b, m_s);
        m_cnt  = latency(m_op);
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          exp_out = m_res;
          exp_fin = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("cyc_out", MemMatOut, exp_out);
    chk("cyc_fin", 256'(FinishFlag), 256'(exp_fin));
  end

  task automatic drive(input logic l1, input logic l2, input logic [7:0] op,
                       input logic [7:0] s, input logic [255:0] m);
    Load_Matrix1 = l1; Load_Matrix2 = l2; Op_Code = op; SOURCE2 = s; MemMatIn = m;
    @(posedge clk); #1;
    Load_Matrix1 = 1'b0; Load_Matrix2 = 1'b0;
  endtask

  task automatic wait_fin(input string name, input int want, input int max);
    int n;
    n = 0;
    while (!FinishFlag && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 256'(n), 256'(want));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [255:0] seq_m, ident_m, tr_m, sc_a, sc_exp;

  initial begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        seq_m[8'((4 * r + c) * 16) +: 16]   = 16'(4 * r + c);
        ident_m[8'((4 * r + c) * 16) +: 16] = (r == c) ? 16'd1 : 16'd0;
        tr_m[8'((4 * r + c) * 16) +: 16]    = 16'(4 * c + r);
      end
    end
    sc_a = fill(16'd1);
    sc_a[15:0] = 16'h1000; sc_a[31:16] = 16'd1000; sc_a[47:32] = 16'h8000;
    sc_exp = fill(16'd42);
    sc_exp[15:0] = 16'hA000; sc_exp[31:16] = 16'd42000; sc_exp[47:32] = 16'h0000;

    idle(3);
    reset = 1'b0;
    chk("rst_out", MemMatOut, '0);
    chk("rst_fin", 256'(FinishFlag), 256'(0));

    // ADD
    drive(1, 0, ADD, 8'd0, fill(16'd3));
    chk("add_wait_fin", 256'(FinishFlag), 256'(0));
    drive(0, 1, 8'd0, 8'd0, fill(16'd5));
    wait_fin("add_lat", 4, 40);
    chk("add_out", MemMatOut, fill(16'd8));
    chk("model_add", exp_out, fill(16'd8));

    // MULTI identity x seq
    drive(1, 0, MULTI, 8'd0, ident_m);
    chk("multi_fin_clr", 256'(FinishFlag), 256'(0));
    chk("multi_out_hold", MemMatOut, fill(16'd8));
    drive(0, 1, 8'd0, 8'd0, seq_m);
    wait_fin("multi_lat", 16, 40);
    chk("multi_out", MemMatOut, seq_m);

    // Load_Matrix2 in DONE only updates B
    drive(0, 1, 8'd0, 8'd0, fill(16'h7777));
    idle(2);
    chk("done_b_fin", 256'(FinishFlag), 256'(1));
    chk("done_b_out", MemMatOut, seq_m);

    // SCALE 42, B ignored
    drive(1, 0, SCALE, 8'd42, sc_a);
    wait_fin("scale_lat", 4, 40);
    chk("scale_out", MemMatOut, sc_exp);

    // TRANS
    drive(1, 0, TRANS, 8'd0, seq_m);
    wait_fin("trans_lat", 4, 40);
    chk("trans_out", MemMatOut, tr_m);
    chk("model_trans", exp_out, tr_m);

    // SUB wrap
    drive(1, 0, SUB, 8'd0, '0);
    drive(0, 1, 8'd0, 8'd0, fill(16'd1));
    wait_fin("sub_lat", 4, 40);
    chk("sub_out", MemMatOut, fill(16'hFFFF));

    // Reset before the 8th MULTI compute edge
    drive(1, 0, MULTI, 8'd0, seq_m);
    drive(0, 1, 8'd0, 8'd0, seq_m);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_out", MemMatOut, '0);
    chk("rst_mid_fin", 256'(FinishFlag), 256'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Load_Matrix2 in IDLE does not start a computation
    drive(0, 1, 8'd0, 8'd0, fill(16'd9));
    idle(20);
    chk("idle_b_fin", 256'(FinishFlag), 256'(0));
    chk("idle_b_out", MemMatOut, '0);

    // Abort MULTI with a simultaneous-load ADD
    drive(1, 0, MULTI, 8'd0, seq_m);
    drive(0, 1, 8'd0, 8'd0, ident_m);
    idle(5);
    drive(1, 1, ADD, 8'd0, fill(16'd100));
    chk("abort_fin", 256'(FinishFlag), 256'(0));
    wait_fin("sim_lat", 4, 40);
    chk("sim_out", MemMatOut, fill(16'd200));
    idle(20);
    chk("abort_no_stale", MemMatOut, fill(16'd200));

    // Unknown ops
    drive(1, 0, 8'hFF, 8'd0, seq_m);
    chk("unk_fin_clr", 256'(FinishFlag), 256'(0));
    wait_fin("unk_lat", 1, 10);
    chk("unk_out", MemMatOut, '0);
    drive(1, 0, 8'h00, 8'd0, seq_m);
    wait_fin("unk0_lat", 1, 10);
    chk("unk0_out", MemMatOut, '0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
